maxnet_controller: RTL

//  Sequences one Maxnet winner-take-all run over the shared float multiply-accumulate datapath.
//  The upper-triangular symmetric weight store holds index 0->w00 .. 9->w33 for N=4.
//  Per iteration: each neuron i accumulates sum_j w(i,j)*x_j, writes relu(acc) to y_i, then all y commit to x.

---
 rtl/maxnet_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/maxnet_controller.sv
// maxnet_controller
//   Runs one Maxnet winner-take-all pass over a shared floating-point MAC
//   datapath. Each iteration visits every neuron i. For each i it clears the
//   accumulator, issues one MAC per operand j using the symmetric
//   upper-triangular weight index, and writes relu(acc) to y[i]. After the
//   last neuron it commits y into x and then checks how many neurons are still
//   nonzero. The run stops when at most one neuron is nonzero.
//
// Optional feature (compile-time macro MAXNET_ITER_LIMIT_EN):
//   Defined   - stop with timeout=1 once iter_count reaches MAX_ITER while more
//               than one neuron is still nonzero.
//   Undefined - no iteration limit; timeout is tied to 0 and MAX_ITER is unused.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin a run (sampled only when idle or done)
//   mac_done        MAC finished the op launched by mac_go (used only in WAIT)
//   nz_count        number of nonzero x after commit (sampled in EVAL)
//   w_idx, x_sel    weight index and operand neuron for the current MAC
//   mac_go          1-cycle pulse: acc += w[w_idx] * x[x_sel]
//   acc_clr         1-cycle pulse: acc <= 0
//   wr_en, wr_sel   1-cycle pulse: y[wr_sel] <= relu(acc)
//   commit          1-cycle pulse: x <= y
//   busy, done      run in progress / run finished (flags valid)
//   all_zero        finished with no neuron left nonzero
//   timeout         finished because the iteration limit was reached
//   iter_count      iterations completed in the current or last run
module maxnet_controller #(
  parameter int N        = 4,
  parameter int IDX_W    = 4,
  parameter int SEL_W    = 2,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mac_done,
  input  logic [SEL_W:0]    nz_count,
  output logic [IDX_W-1:0]  w_idx,
  output logic [SEL_W-1:0]  x_sel,
  output logic              mac_go,
  output logic              acc_clr,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic              commit,
  output logic              busy,
  output logic              done,
  output logic              all_zero,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_WRITE, S_COMMIT, S_EVAL, S_DONE
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  i_q, i_d, j_q, j_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              az_q, az_d;
`ifdef MAXNET_ITER_LIMIT_EN
  logic              to_q, to_d;
`endif

  // Row-major packing of the upper triangle, using a = min, b = max.
  // a*N - a*(a-1)/2 is rewritten as a*(2N-a+1)/2 so that a=0 does not
  // underflow.
  function automatic logic [IDX_W-1:0] tri_idx(input logic [SEL_W-1:0] r,
                                                input logic [SEL_W-1:0] c);
    int a, b;
    a = (r < c) ? int'(r) : int'(c);
    b = (r < c) ? int'(c) : int'(r);
    return IDX_W'((a * (2 * N - a + 1)) / 2 + (b - a));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      iter_q  <= '0;
      az_q    <= 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      iter_q  <= iter_d;
      az_q    <= az_d;
`ifdef MAXNET_ITER_LIMIT_EN
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    iter_d  = iter_q;
    az_d    = az_q;
`ifdef MAXNET_ITER_LIMIT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          i_d     = '0;
          iter_d  = '0;
          az_d    = 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
          to_d    = 1'b0;
`endif
        end
      end
      S_CLEAR: begin
        j_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mac_done) begin
          if (j_q == LAST) begin
            state_d = S_WRITE;
          end else begin
            j_d     = j_q + SEL_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_WRITE: begin
        if (i_q == LAST) begin
          state_d = S_COMMIT;
        end else begin
          i_d     = i_q + SEL_W'(1);
          state_d = S_CLEAR;
        end
      end
      S_COMMIT: begin
        i_d     = '0;
        // The count saturates so that a very long run never wraps back to 0.
        iter_d  = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (nz_count <= (SEL_W+1)'(1)) begin
          state_d = S_DONE;
          az_d    = (nz_count == '0);
        end
`ifdef MAXNET_ITER_LIMIT_EN
        else if (iter_q == ITER_W'(MAX_ITER)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
`endif
        else begin
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only. i and j do not change
  // between ISSUE and the end of WAIT, so w_idx and x_sel stay stable for the
  // whole MAC.
  always_comb begin
    w_idx      = tri_idx(i_q, j_q);
    x_sel      = j_q;
    wr_sel     = i_q;
    mac_go     = (state_q == S_ISSUE);
    acc_clr    = (state_q == S_CLEAR);
    wr_en      = (state_q == S_WRITE);
    commit     = (state_q == S_COMMIT);
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    done       = (state_q == S_DONE);
    all_zero   = az_q;
    iter_count = iter_q;
  end

`ifdef MAXNET_ITER_LIMIT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
  logic unused_max_iter;
  assign unused_max_iter = ^ITER_W'(MAX_ITER);
`endif

endmodule
